inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction-fetch front end of the pipeline.
- Generates the PC and issues requests to the instruction memory over a valid/ready request and in-order response interface.
- Buffers returned instructions and delivers if_id_reg_t entries to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the credit limit on outstanding requests plus buffered entries (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  fetch address (current PC).
- imem_rsp_valid  input  1  response valid; in order, cannot be back-pressured.
- imem_rsp_data  input  32  returned instruction.
- redirect_i  input  1  branch/jump taken; flush and restart.
- redirect_pc_i  input  32  restart address.
- if_id_valid_o  output  1  entry valid to decode.
- if_id_ready_i  input  1  decode accepts entry.
- if_id_o  output  96  if_id_reg_t {current_pc, pc_plus_4, inst}.

Behaviour:
- Reset (asynchronous, immediate):
  - pc = RESET_PC; state = FETCH; outstanding = 0.
  - FIFO and PC tag queue empty.
  - imem_req_valid = 0; if_id_valid_o = 0; if_id_o = 0.
- Request issue:
  - imem_req_valid = (state==FETCH) & ~redirect_i & (outstanding + fifo_count < FIFO_DEPTH).
  - imem_req_addr = pc.
  - On handshake: pc <= pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC); push pc into the tag queue; outstanding increments.
  - While imem_req_ready is low, valid and addr hold stable.
- Response handling:
  - On imem_rsp_valid in FETCH: pop the tag queue and push {tag, tag+4, imem_rsp_data} into the FIFO; outstanding decrements.
  - The credit rule guarantees the FIFO never overflows.
  - Handshake and response in the same cycle leave outstanding unchanged.
- Output:
  - if_id_valid_o = FIFO non-empty; if_id_o = FIFO head.
  - Pop on if_id_valid_o & if_id_ready_i.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full or empty.
  - Latency from rsp_valid to if_id_valid_o is 1 cycle.
- State FETCH, on redirect_i:
  - pc <= redirect_pc_i; FIFO flushed; tag queue cleared.
  - No request is issued that cycle.
  - If outstanding after this cycle's response is 0, stay in FETCH. Otherwise go to FLUSH.
- State FLUSH:
  - No requests issued.
  - Every response is discarded and outstanding decrements.
  - When outstanding reaches 0, go to FETCH the next cycle.
  - A redirect in FLUSH updates pc and stays in FLUSH.
- Priority: redirect over output pop/push, which happen the same cycle; reset over everything.
- Protocol error: imem_rsp_valid with outstanding==0 is illegal; a simulation assertion fires and the response is ignored.
- No misalignment check: pc[1:0] always 0 given aligned RESET_PC and redirects.

Optional Feature:
- Macro: IF_BYPASS_EN.
- Defined: when the FIFO is empty, state==FETCH and a response arrives, the response drives if_id_o / if_id_valid_o combinationally in the same cycle. If if_id_ready_i is high it is consumed without entering the FIFO; otherwise it is pushed. Latency is 0.
- Undefined: latency is always 1 cycle; no combinational path from imem_rsp_* to if_id_*.

Decomposition:
- riscv_types package additions:
  - fetch_state_t enum {FETCH, FLUSH}.
  - Reuse if_id_reg_t as the FIFO payload and output type.
  - Constant INST_BYTES = 4.
- Sub-module inst_fetch_fifo: synchronous FIFO parameterized by WIDTH and DEPTH, with push, pop, flush (flush wins over push), count, empty and full outputs. It is instantiated twice: for the PC tag queue (WIDTH 32) and for the instruction buffer (WIDTH 96).

Test Plan:
- Streaming: RESET_PC=32'h8000_0000, req_ready=1, 1-cycle response latency, ready=1 -> addresses 0x8000_0000, 0x8000_0004, ... each cycle; if_id_o pc/pc_plus_4/inst match the memory image.
- Backpressure: if_id_ready_i=0 -> exactly 2 requests issued, then imem_req_valid=0; release after 10 cycles -> entries in order, none lost or duplicated.
- Redirect with 2 outstanding to 32'h0000_0100 -> FLUSH entered, both responses discarded, next request addr 0x100, first output current_pc=0x100.
- Redirect with FIFO full and 0 outstanding -> if_id_valid_o=0 next cycle, state stays FETCH, request 0x100 issued the next cycle.
- req_ready=0 for 5 cycles -> imem_req_valid high, imem_req_addr stable; PC wrap from 32'hFFFF_FFFC -> next addr 0.
- reset_n asserted during FLUSH with 1 outstanding -> all outputs reset immediately; after release, state FETCH, first addr RESET_PC.

Source files
------------

// File: rtl/riscv_types_pkg.sv
// Shared pipeline types used by the instruction-fetch front end.
package riscv_types;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH,
        FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] current_pc;
        logic [31:0] pc_plus_4;
        logic [31:0] inst;
    } if_id_reg_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO used for the fetch PC tag queue and the instruction buffer.
// Flush wins over push; pop of an empty FIFO is ignored.
module inst_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign pop_en  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_en = push & (~full | pop_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_en) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited imem requests, buffering, redirects.
// Define IF_BYPASS_EN to let a response reach decode in the same cycle when the buffer is empty.
module inst_fetch_unit
    import riscv_types::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_id_valid_o,
    input  logic        if_id_ready_i,
    output if_id_reg_t  if_id_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;

    logic             credit_ok;
    logic             req_fire;
    logic             rsp_ok;
    logic             rsp_fetch;

    logic [31:0]      tag_head;
    logic [CNT_W-1:0] tag_count;
    logic             tag_empty;
    logic             tag_full;

    if_id_reg_t       rsp_entry;
    if_id_reg_t       buf_head;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;
    logic             buf_full;
    logic             buf_push;
    logic             buf_pop;

    // Outstanding requests plus buffered entries never exceed the buffer depth.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_count}) < (CNT_W + 1)'(FIFO_DEPTH);

    assign imem_req_valid = reset_n & (state_q == FETCH) & ~redirect_i & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_ok    = imem_rsp_valid & (outstanding_q != '0);
    assign rsp_fetch = rsp_ok & (state_q == FETCH);

    assign rsp_entry.current_pc = tag_head;
    assign rsp_entry.pc_plus_4  = tag_head + 32'(INST_BYTES);
    assign rsp_entry.inst       = imem_rsp_data;

    assign buf_pop = ~buf_empty & if_id_ready_i;

`ifdef IF_BYPASS_EN
    logic bypass;

    assign bypass        = buf_empty & rsp_fetch & ~redirect_i;
    assign if_id_valid_o = ~buf_empty | bypass;
    assign if_id_o       = ~buf_empty ? buf_head : (bypass ? rsp_entry : '0);
    assign buf_push      = rsp_fetch & ~(bypass & if_id_ready_i);
`else
    assign if_id_valid_o = ~buf_empty;
    assign if_id_o       = buf_empty ? '0 : buf_head;
    assign buf_push      = rsp_fetch;
`endif

    always_comb begin
        outstanding_d = outstanding_q;
        case ({req_fire, rsp_ok})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            unique case (state_q)
                FETCH: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_pc_i;
                        state_q <= (outstanding_d != '0) ? FLUSH : FETCH;
                    end else if (req_fire) begin
                        pc_q <= pc_q + 32'(INST_BYTES);
                    end
                end
                FLUSH: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_i;
                    end
                    if (outstanding_d == '0) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    inst_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_fetch),
        .flush     (redirect_i),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    inst_fetch_fifo #(
        .WIDTH ($bits(if_id_reg_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (buf_push),
        .push_data (rsp_entry),
        .pop       (buf_pop),
        .flush     (redirect_i),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    // A response with nothing outstanding is a memory protocol error and is dropped.
    a_rsp_without_req: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rsp_valid && outstanding_q == '0));

    a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == FETCH) |-> (tag_count == outstanding_q));

    a_tag_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp_fetch && tag_empty));

    a_tag_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(req_fire && tag_full && !rsp_fetch));

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle-latency in-order memory model.
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] INST_K = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic        if_id_ready;
    logic [95:0] if_id;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_req = 0;
    int          n_out = 0;
    int          n0;
    logic [31:0] exp_req_addr;
    logic [31:0] exp_pc;
    logic        mem_hold = 1'b0;
    logic [31:0] pend_q[$];

    inst_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .if_id_valid_o  (if_id_valid),
        .if_id_ready_i  (if_id_ready),
        .if_id_o        (if_id)
    );

    always #5 clk = ~clk;

    // Memory: answers each accepted request exactly one cycle later unless held.
    always @(posedge clk) begin
        logic [31:0] a;
        #2;
        if (pend_q.size() != 0 && !mem_hold) begin
            a              = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = a ^ INST_K;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #6;
        if (reset_n && imem_req_valid && imem_req_ready) begin
            pend_q.push_back(imem_req_addr);
        end
    end

    task automatic check(input string name, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle.
    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    // Score the request and output handshakes that will happen at the next edge, then advance.
    task automatic step();
        logic [95:0] e;
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", {64'd0, imem_req_addr}, {64'd0, exp_req_addr});
            exp_req_addr = exp_req_addr + 32'd4;
            n_req++;
        end
        if (if_id_valid && if_id_ready) begin
            e = {exp_pc, exp_pc + 32'd4, exp_pc ^ INST_K};
            check("if_id_entry", if_id, e);
            exp_pc = exp_pc + 32'd4;
            n_out++;
        end
        tick();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_outputs(input int k, input int max_cyc, input string name);
        int base;
        base = n_out;
        for (int i = 0; i < max_cyc && (n_out - base) < k; i++) step();
        check(name, 96'(n_out - base), 96'(k));
    endtask

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        if_id_ready    = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        exp_req_addr   = RST_PC;
        exp_pc         = RST_PC;

        tick();
        tick();
        check("rst_req_valid", 96'(imem_req_valid), 96'd0);
        check("rst_if_id_valid", 96'(if_id_valid), 96'd0);
        check("rst_if_id", if_id, 96'd0);
        check("rst_req_addr", {64'd0, imem_req_addr}, {64'd0, RST_PC});
        reset_n = 1'b1;

        // Memory not ready: request must hold valid and address.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req_valid", 96'(imem_req_valid), 96'd1);
            check("stall_req_addr", {64'd0, imem_req_addr}, {64'd0, RST_PC});
        end

        imem_req_ready = 1'b1;
        wait_outputs(8, 40, "stream_count");

        // Drain, then back-pressure decode: only two requests fit in the credit budget.
        imem_req_ready = 1'b0;
        run_cycles(4);
        if_id_ready    = 1'b0;
        imem_req_ready = 1'b1;
        n0 = n_req;
        run_cycles(12);
        check("bp_req_count", 96'(n_req - n0), 96'd2);
        check("bp_req_valid", 96'(imem_req_valid), 96'd0);
        check("bp_if_id_valid", 96'(if_id_valid), 96'd1);
        if_id_ready = 1'b1;
        n0 = n_out;
        run_cycles(2);
        check("bp_release_count", 96'(n_out - n0), 96'd2);

        // Redirect with two requests outstanding: both responses must be dropped.
        imem_req_ready = 1'b0;
        run_cycles(4);
        mem_hold       = 1'b1;
        imem_req_ready = 1'b1;
        n0 = n_req;
        run_cycles(3);
        check("rd2_req_count", 96'(n_req - n0), 96'd2);
        check("rd2_credit_stall", 96'(imem_req_valid), 96'd0);
        redirect     = 1'b1;
        redirect_pc  = 32'h0000_0100;
        exp_req_addr = 32'h0000_0100;
        exp_pc       = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        mem_hold = 1'b0;
        #1;
        check("rd2_flush_req_valid", 96'(imem_req_valid), 96'd0);
        tick();
        check("rd2_drop0_valid", 96'(if_id_valid), 96'd0);
        check("rd2_drop0_req", 96'(imem_req_valid), 96'd0);
        tick();
        check("rd2_drop1_valid", 96'(if_id_valid), 96'd0);
        check("rd2_drop1_req", 96'(imem_req_valid), 96'd0);
        tick();
        check("rd2_resume_valid", 96'(imem_req_valid), 96'd1);
        check("rd2_resume_addr", {64'd0, imem_req_addr}, 96'h100);
        n0 = n_out;
        run_cycles(4);
        check("rd2_out_count", 96'(n_out - n0), 96'd2);

        // Redirect with the buffer full and nothing outstanding.
        if_id_ready = 1'b0;
        run_cycles(6);
        check("rdf_full_valid", 96'(if_id_valid), 96'd1);
        check("rdf_full_req", 96'(imem_req_valid), 96'd0);
        redirect     = 1'b1;
        redirect_pc  = 32'h0000_0100;
        exp_req_addr = 32'h0000_0100;
        exp_pc       = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        #1;
        check("rdf_flushed_valid", 96'(if_id_valid), 96'd0);
        check("rdf_req_valid", 96'(imem_req_valid), 96'd1);
        check("rdf_req_addr", {64'd0, imem_req_addr}, 96'h100);
        if_id_ready = 1'b1;
        n0 = n_out;
        run_cycles(4);
        check("rdf_out_count", 96'(n_out - n0), 96'd2);

        // PC wrap across the top of the address space.
        redirect     = 1'b1;
        redirect_pc  = 32'hFFFF_FFF8;
        exp_req_addr = 32'hFFFF_FFF8;
        exp_pc       = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        #1;
        wait_outputs(4, 30, "wrap_count");

        // Reset while flushing with one response still outstanding.
        imem_req_ready = 1'b0;
        run_cycles(4);
        mem_hold       = 1'b1;
        imem_req_ready = 1'b1;
        exp_req_addr   = imem_req_addr;
        step();
        imem_req_ready = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        #1;
        check("fl_req_valid", 96'(imem_req_valid), 96'd0);
        reset_n = 1'b0;
        pend_q.delete();
        mem_hold = 1'b0;
        #1;
        check("arst_req_valid", 96'(imem_req_valid), 96'd0);
        check("arst_if_id_valid", 96'(if_id_valid), 96'd0);
        check("arst_if_id", if_id, 96'd0);
        check("arst_req_addr", {64'd0, imem_req_addr}, {64'd0, RST_PC});
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("post_rst_req_valid", 96'(imem_req_valid), 96'd1);
        check("post_rst_req_addr", {64'd0, imem_req_addr}, {64'd0, RST_PC});
        exp_req_addr   = RST_PC;
        exp_pc         = RST_PC;
        imem_req_ready = 1'b1;
        wait_outputs(2, 20, "post_rst_count");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
